// File: rtl/reset_sequencer.sv
// Staged reset controller: qualifies board reset, releases peripherals ahead of the CPU,
// and re-sequences on software request or watchdog expiry while recording the cause.
module reset_sequencer #(
  parameter int unsigned CLOCK_FREQ  = 6000000,
  parameter int unsigned POR_CYCLES  = 10000,
  parameter int unsigned PERIPH_LEAD = 16,
  parameter int unsigned SOFT_HOLD   = 8,
  parameter int unsigned WDT_CYCLES  = 6000000
) (
  input  logic       clk,
  input  logic       RSTb,
  input  logic       SOFT_RST_REQ,
  input  logic       WDT_EN,
  input  logic       WDT_KICK,
  output logic       PERIPH_RSTb,
  output logic       CPU_RSTb,
  output logic [1:0] RST_CAUSE,
  output logic [7:0] RST_COUNT,
  output logic       BUSY
);

  localparam int unsigned CNT_MAX =
    (POR_CYCLES > PERIPH_LEAD) ? ((POR_CYCLES > SOFT_HOLD) ? POR_CYCLES : SOFT_HOLD)
                               : ((PERIPH_LEAD > SOFT_HOLD) ? PERIPH_LEAD : SOFT_HOLD);
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned WW = $clog2(WDT_CYCLES);

  localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] LEAD_LAST = CW'(PERIPH_LEAD - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SOFT_HOLD - 1);
  localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_CYCLES - 1);

  localparam logic [1:0] S_POR    = 2'd0;
  localparam logic [1:0] S_PERIPH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_SOFT   = 2'd3;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

  if (CLOCK_FREQ == 0 || PERIPH_LEAD < 1 || SOFT_HOLD < 1 || WDT_CYCLES < 2 || POR_CYCLES < 1) begin : g_param_check
    $error("reset_sequencer: illegal parameter combination");
  end

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_wdt;
  logic          r_periph_rstb;
  logic          r_cpu_rstb;
  logic          r_busy;
  logic [1:0]    r_cause;
  logic [7:0]    r_rst_count;
  logic          w_wdt_expire;

  // A kick on the expiry edge suppresses expiry.
  assign w_wdt_expire = (r_state == S_RUN) && WDT_EN && !WDT_KICK && (r_wdt == WDT_LAST);

  always_ff @(posedge clk) begin
    if (!RSTb || r_state != S_RUN || !WDT_EN || WDT_KICK || w_wdt_expire) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= r_wdt + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTb) begin
      r_state       <= S_POR;
      r_cnt         <= '0;
      r_periph_rstb <= 1'b0;
      r_cpu_rstb    <= 1'b0;
      r_busy        <= 1'b1;
      r_cause       <= CAUSE_POR;
      r_rst_count   <= '0;
    end else begin
      case (r_state)
        S_POR: begin
          if (r_cnt == POR_LAST) begin
            r_state       <= S_PERIPH;
            r_cnt         <= '0;
            r_periph_rstb <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PERIPH: begin
          if (r_cnt == LEAD_LAST) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_cpu_rstb <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RUN: begin
          // Software request outranks a coincident watchdog expiry.
          if (SOFT_RST_REQ || w_wdt_expire) begin
            r_state       <= S_SOFT;
            r_cnt         <= '0;
            r_periph_rstb <= 1'b0;
            r_cpu_rstb    <= 1'b0;
            r_busy        <= 1'b1;
            r_cause       <= SOFT_RST_REQ ? CAUSE_SOFT : CAUSE_WDT;
            if (r_rst_count != 8'hFF) begin
              r_rst_count <= r_rst_count + 8'd1;
            end
          end
        end
        S_SOFT: begin
          if (r_cnt == HOLD_LAST) begin
            r_state       <= S_PERIPH;
            r_cnt         <= '0;
            r_periph_rstb <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_POR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign PERIPH_RSTb = r_periph_rstb;
  assign CPU_RSTb    = r_cpu_rstb;
  assign BUSY        = r_busy;
  assign RST_CAUSE   = r_cause;
  assign RST_COUNT   = r_rst_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with POR_CYCLES=10, PERIPH_LEAD=4, SOFT_HOLD=3, WDT_CYCLES=20.
// Observed outputs are packed as {PERIPH_RSTb, CPU_RSTb, BUSY, RST_CAUSE[1:0], RST_COUNT[7:0]}.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       RSTb = 1'b0;
  logic       SOFT_RST_REQ = 1'b0;
  logic       WDT_EN = 1'b0;
  logic       WDT_KICK = 1'b0;
  logic       PERIPH_RSTb;
  logic       CPU_RSTb;
  logic [1:0] RST_CAUSE;
  logic [7:0] RST_COUNT;
  logic       BUSY;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [12:0] exp_v;
  logic [12:0] obs;

  assign obs = {PERIPH_RSTb, CPU_RSTb, BUSY, RST_CAUSE, RST_COUNT};

  always #5 clk = ~clk;

  reset_sequencer #(
    .CLOCK_FREQ (6000000),
    .POR_CYCLES (10),
    .PERIPH_LEAD(4),
    .SOFT_HOLD  (3),
    .WDT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .RSTb        (RSTb),
    .SOFT_RST_REQ(SOFT_RST_REQ),
    .WDT_EN      (WDT_EN),
    .WDT_KICK    (WDT_KICK),
    .PERIPH_RSTb (PERIPH_RSTb),
    .CPU_RSTb    (CPU_RSTb),
    .RST_CAUSE   (RST_CAUSE),
    .RST_COUNT   (RST_COUNT),
    .BUSY        (BUSY)
  );

  // Advance n rising edges; returns at the following falling edge.
  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    RSTb = 1'b0;
    step(5);
    exp_v = {1'b0, 1'b0, 1'b1, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_values: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_por();
    RSTb = 1'b1;
    step(9);
    exp_v = {1'b0, 1'b0, 1'b1, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL por_edge9: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b1, 1'b0, 1'b1, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL por_edge10: got %b want %b", obs, exp_v); end
    step(3);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL por_edge13: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL por_edge14: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_soft();
    SOFT_RST_REQ = 1'b1;
    step(1);
    SOFT_RST_REQ = 1'b0;
    exp_v = {1'b0, 1'b0, 1'b1, 2'b01, 8'd1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL soft_enter: got %b want %b", obs, exp_v); end
    step(2);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL soft_hold_n2: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b1, 1'b0, 1'b1, 2'b01, 8'd1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL soft_periph_n3: got %b want %b", obs, exp_v); end
    step(3);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL soft_cpu_low_n6: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b01, 8'd1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL soft_cpu_high_n7: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_watchdog();
    logic low_seen;
    WDT_EN = 1'b1;
    step(19);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b01, 8'd1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wdt_r19: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b0, 1'b0, 1'b1, 2'b10, 8'd2}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wdt_expire_r20: got %b want %b", obs, exp_v); end
    step(7);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b10, 8'd2}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wdt_rerelease: got %b want %b", obs, exp_v); end
    low_seen = 1'b0;
    for (int unsigned blk = 0; blk < 14; blk++) begin
      for (int unsigned j = 0; j < 15; j++) begin
        if (j == 14) WDT_KICK = 1'b1;
        step(1);
        WDT_KICK = 1'b0;
        if (CPU_RSTb !== 1'b1) low_seen = 1'b1;
      end
    end
    checks++;
    if (low_seen !== 1'b0) begin errors++; $display("FAIL wdt_kicked_no_reset: got low_seen=%b want 0", low_seen); end
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wdt_kicked_state: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_collisions();
    step(19);
    SOFT_RST_REQ = 1'b1;
    step(1);
    SOFT_RST_REQ = 1'b0;
    exp_v = {1'b0, 1'b0, 1'b1, 2'b01, 8'd3}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL collide_soft_wins: got %b want %b", obs, exp_v); end
    step(7);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b01, 8'd3}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL collide_soft_release: got %b want %b", obs, exp_v); end
    step(19);
    WDT_KICK = 1'b1;
    step(1);
    WDT_KICK = 1'b0;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL collide_kick_wins: got %b want %b", obs, exp_v); end
    step(19);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL kick_cleared_q39: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b0, 1'b0, 1'b1, 2'b10, 8'd4}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL kick_cleared_q40: got %b want %b", obs, exp_v); end
    WDT_EN = 1'b0;
    step(7);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b10, 8'd4}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL collide_final_run: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_mid_reset();
    SOFT_RST_REQ = 1'b1;
    step(1);
    SOFT_RST_REQ = 1'b0;
    step(3);
    exp_v = {1'b1, 1'b0, 1'b1, 2'b01, 8'd5}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_in_periph: got %b want %b", obs, exp_v); end
    step(1);
    RSTb = 1'b0;
    step(1);
    RSTb = 1'b1;
    exp_v = {1'b0, 1'b0, 1'b1, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_periph_reset: got %b want %b", obs, exp_v); end
    step(9);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_periph_edge9: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b1, 1'b0, 1'b1, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_periph_edge10: got %b want %b", obs, exp_v); end
    step(3);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_periph_edge13: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_periph_edge14: got %b want %b", obs, exp_v); end
    SOFT_RST_REQ = 1'b1;
    step(1);
    SOFT_RST_REQ = 1'b0;
    step(1);
    exp_v = {1'b0, 1'b0, 1'b1, 2'b01, 8'd1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_in_soft: got %b want %b", obs, exp_v); end
    RSTb = 1'b0;
    step(1);
    RSTb = 1'b1;
    exp_v = {1'b0, 1'b0, 1'b1, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_soft_reset: got %b want %b", obs, exp_v); end
    step(9);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_soft_edge9: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b1, 1'b0, 1'b1, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_soft_edge10: got %b want %b", obs, exp_v); end
    step(4);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b00, 8'd0}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL mid_soft_edge14: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_ignored();
    SOFT_RST_REQ = 1'b1;
    step(1);
    SOFT_RST_REQ = 1'b0;
    step(3);
    SOFT_RST_REQ = 1'b1;
    step(1);
    SOFT_RST_REQ = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b1, 2'b01, 8'd1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ignore_in_periph: got %b want %b", obs, exp_v); end
    step(2);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ignore_n6: got %b want %b", obs, exp_v); end
    step(1);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b01, 8'd1}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ignore_n7_release: got %b want %b", obs, exp_v); end
    SOFT_RST_REQ = 1'b1;
    step(8);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b01, 8'd2}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL held_release_m7: got %b want %b", obs, exp_v); end
    step(1);
    SOFT_RST_REQ = 1'b0;
    exp_v = {1'b0, 1'b0, 1'b1, 2'b01, 8'd3}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL held_retrigger_m8: got %b want %b", obs, exp_v); end
    step(7);
    exp_v = {1'b1, 1'b1, 1'b0, 2'b01, 8'd3}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL held_final_run: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_saturation();
    for (int unsigned i = 0; i < 260; i++) begin
      SOFT_RST_REQ = 1'b1;
      step(1);
      SOFT_RST_REQ = 1'b0;
      step(7);
      if (i == 250) begin
        checks++;
        if (RST_COUNT !== 8'd254) begin errors++; $display("FAIL sat_count_254: got %0d want 254", RST_COUNT); end
      end
      if (i == 251) begin
        checks++;
        if (RST_COUNT !== 8'd255) begin errors++; $display("FAIL sat_count_255: got %0d want 255", RST_COUNT); end
      end
    end
    exp_v = {1'b1, 1'b1, 1'b0, 2'b01, 8'd255}; checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sat_final: got %b want %b", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_por();
    test_soft();
    test_watchdog();
    test_collisions();
    test_mid_reset();
    test_ignored();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Power-on and run-time reset controller for the slurm16 SoC on iCE40.
- Qualifies the board-level reset.
- Releases peripheral reset first and CPU reset a fixed number of cycles later.
- Provides a software-requested reset and a watchdog that re-sequences the system when not kicked.
- Sits between the top-level reset counter and the slurm16 core/peripherals; reports the cause of the last reset.

Parameters:
CLOCK_FREQ, 6000000, system clock in Hz (informational; WDT_CYCLES derivation by integrator)
POR_CYCLES, 10000, cycles RSTb must stay high before peripherals are released
PERIPH_LEAD, 16, cycles between peripheral release and CPU release (>=1)
SOFT_HOLD, 8, cycles both resets are held low for a soft/watchdog reset (>=1)
WDT_CYCLES, 6000000, watchdog timeout in cycles (>=2)

Ports:
clk  in  1  system clock
RSTb  in  1  synchronous active-low reset, sampled on posedge clk
SOFT_RST_REQ  in  1  software reset request; level sampled each cycle
WDT_EN  in  1  watchdog enable
WDT_KICK  in  1  watchdog restart; single-cycle pulse expected
PERIPH_RSTb  out  1  active-low peripheral reset, registered
CPU_RSTb  out  1  active-low CPU reset, registered
RST_CAUSE  out  2  last reset cause: 00 POR, 01 soft, 10 watchdog; 11 unused
RST_COUNT  out  8  saturating count of soft plus watchdog resets since POR
BUSY  out  1  high whenever state != S_RUN

Behaviour:
- All outputs are registers updated on posedge clk. No combinational paths from inputs to outputs.
- RSTb=0 on any edge forces the block to reset values on that edge, from any state, including mid-sequence:
  - state S_POR, all counters 0
  - PERIPH_RSTb=0, CPU_RSTb=0
  - RST_CAUSE=00, RST_COUNT=0, BUSY=1
- States:
  - S_POR: both resets low. cnt increments on each edge with RSTb=1. On the edge where cnt==POR_CYCLES-1: go to S_PERIPH, cnt=0, PERIPH_RSTb=1.
  - S_PERIPH: PERIPH_RSTb=1, CPU_RSTb=0. cnt increments. On the edge where cnt==PERIPH_LEAD-1: go to S_RUN, CPU_RSTb=1, BUSY=0, wdt=0.
  - S_RUN: both resets high.
    - SOFT_RST_REQ=1 on an edge: go to S_SOFT, both resets low, RST_CAUSE=01.
    - Otherwise, on watchdog expiry: go to S_SOFT, RST_CAUSE=10.
    - RST_COUNT increments (saturates at 255) on either transition into S_SOFT.
  - S_SOFT: both resets low, BUSY=1. cnt increments. On the edge where cnt==SOFT_HOLD-1: go to S_PERIPH with cnt=0 (normal staged release follows). RST_CAUSE holds its value.
- Watchdog counter (wdt, width $clog2(WDT_CYCLES)):
  - Active only in S_RUN. Cleared on entry to S_RUN, on WDT_KICK=1, and while WDT_EN=0.
  - Otherwise increments each edge.
  - Expiry = WDT_EN=1, WDT_KICK=0, wdt==WDT_CYCLES-1. With no kicks, S_RUN therefore lasts exactly WDT_CYCLES cycles.
- Priorities and ignored inputs:
  - Simultaneous SOFT_RST_REQ and expiry: soft wins, cause 01.
  - Simultaneous WDT_KICK and expiry: kick wins, no reset.
  - SOFT_RST_REQ and WDT_KICK are ignored outside S_RUN. A request held high across the release re-triggers on the first S_RUN edge.
- Counter widths: cnt is $clog2 of max(POR_CYCLES, PERIPH_LEAD, SOFT_HOLD)+1. No wrap occurs in any state.

Test Plan:
Use POR_CYCLES=10, PERIPH_LEAD=4, SOFT_HOLD=3, WDT_CYCLES=20.
1. POR: RSTb=0 for 5 cycles, then 1 (edge 1 = first edge with RSTb=1) -> PERIPH_RSTb rises after edge 10, CPU_RSTb after edge 14, BUSY falls after edge 14, RST_CAUSE=00, RST_COUNT=0.
2. Soft reset: in S_RUN, SOFT_RST_REQ=1 for 1 cycle at edge N -> both resets low after N, RST_CAUSE=01, RST_COUNT=1, PERIPH_RSTb high after N+3, CPU_RSTb high after N+7.
3. Watchdog: WDT_EN=1, no kicks from S_RUN entry at edge R -> resets drop after edge R+20, RST_CAUSE=10. With a kick every 15 cycles, no reset over 200 cycles.
4. Collisions: SOFT_RST_REQ and expiry on the same edge -> RST_CAUSE=01. WDT_KICK on the expiry edge -> stays in S_RUN, wdt=0.
5. Reset mid-sequence: RSTb=0 for 1 cycle during S_PERIPH and again during S_SOFT -> all outputs return to reset values next edge, full 10+4 cycle sequence restarts, RST_COUNT=0.
6. Saturation: 260 soft resets -> RST_COUNT=255. SOFT_RST_REQ pulsed during S_PERIPH -> ignored, RST_COUNT unchanged.
